// File: rtl/decode_hazard_forward_pkg.sv
// Shared types for the decode-stage hazard and forwarding logic: bypass select
// encoding and the destination metadata tracked for each in-flight instruction.
package hazard_pkg;

   localparam int REG_ADDR_WIDTH = 5;

   typedef enum logic [1:0] {
      BYP_REGFILE = 2'b00,
      BYP_EXEC    = 2'b01,
      BYP_MEM     = 2'b10,
      BYP_WB      = 2'b11
   } bypass_sel_e;

   typedef struct packed {
      logic                      valid;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic                      wr;
      logic                      load;
   } shadow_entry_t;

   // x0 is hardwired to zero, so it can never be a forwarding source.
   function automatic logic entry_matches(input shadow_entry_t entry,
                                          input logic [REG_ADDR_WIDTH-1:0] addr);
      return entry.valid && entry.wr && (entry.rd == addr) && (addr != '0);
   endfunction

endpackage

// File: rtl/decode_hazard_forward_operand_bypass_select.sv
// Picks the youngest in-flight producer of one source operand and flags a
// load-use hazard when that producer is a load that has not yet reached WB.
module operand_bypass_select
   import hazard_pkg::*;
(
   input  logic [REG_ADDR_WIDTH-1:0] addr,
   input  logic                      used,
   input  logic                      decode_valid,
   input  shadow_entry_t             ex,
   input  shadow_entry_t             mem,
   input  shadow_entry_t             wb,
   output bypass_sel_e               sel,
   output logic                      load_hazard
);

   logic active;

   assign active = used && decode_valid;

   // Youngest stage wins; a load only produces data once it reaches WB.
   always_comb begin
      sel         = BYP_REGFILE;
      load_hazard = 1'b0;
      if (active && entry_matches(ex, addr)) begin
         sel         = BYP_EXEC;
         load_hazard = ex.load;
      end else if (active && entry_matches(mem, addr)) begin
         sel         = BYP_MEM;
         load_hazard = mem.load;
      end else if (active && entry_matches(wb, addr)) begin
         sel         = BYP_WB;
      end
   end

endmodule

// File: rtl/decode_hazard_forward.sv
// Decode-stage forwarding and load-use stall generation, backed by a shadow
// EX/MEM/WB pipeline of destination metadata and a saturating stall counter.
module decode_hazard_forward #(
   parameter int REG_ADDR_WIDTH  = hazard_pkg::REG_ADDR_WIDTH,
   parameter int STALL_CNT_WIDTH = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       decode_valid,
   input  logic [REG_ADDR_WIDTH-1:0]  rs1_addr,
   input  logic [REG_ADDR_WIDTH-1:0]  rs2_addr,
   input  logic                       rs1_used,
   input  logic                       rs2_used,
   input  logic [REG_ADDR_WIDTH-1:0]  rd_addr,
   input  logic                       rd_write,
   input  logic                       is_load,
   input  logic                       flush,
   input  logic                       pipe_hold,
   output logic [1:0]                 rs1_data_bypass,
   output logic [1:0]                 rs2_data_bypass,
   output logic                       hazard_stall,
   output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

   hazard_pkg::shadow_entry_t ex_q, mem_q, wb_q, decode_entry;
   hazard_pkg::bypass_sel_e   rs1_sel, rs2_sel;
   logic                      rs1_load_hazard, rs2_load_hazard;

   operand_bypass_select rs1_select (
      .addr         (rs1_addr),
      .used         (rs1_used),
      .decode_valid (decode_valid),
      .ex           (ex_q),
      .mem          (mem_q),
      .wb           (wb_q),
      .sel          (rs1_sel),
      .load_hazard  (rs1_load_hazard)
   );

   operand_bypass_select rs2_select (
      .addr         (rs2_addr),
      .used         (rs2_used),
      .decode_valid (decode_valid),
      .ex           (ex_q),
      .mem          (mem_q),
      .wb           (wb_q),
      .sel          (rs2_sel),
      .load_hazard  (rs2_load_hazard)
   );

   assign rs1_data_bypass = rs1_sel;
   assign rs2_data_bypass = rs2_sel;

   // A flushed instruction is squashed anyway, so it must not hold the front end.
   assign hazard_stall = (rs1_load_hazard || rs2_load_hazard) && !flush;

   assign decode_entry.valid = decode_valid && !flush && !hazard_stall;
   assign decode_entry.rd    = rd_addr;
   assign decode_entry.wr    = rd_write;
   assign decode_entry.load  = is_load;

   always_ff @(posedge clock) begin
      if (reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else if (!pipe_hold) begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         ex_q  <= decode_entry;
      end
   end

   // Counts only stall cycles that actually cost a pipeline slot; never wraps.
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (hazard_stall && !pipe_hold && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 1'b1;
      end
   end

endmodule

// File: tb/tb_decode_hazard_forward.sv
// Directed bench for decode_hazard_forward: walks through forwarding distances,
// load-use stalls, flush/hold interaction, x0, reset and counter saturation.
module tb_decode_hazard_forward;

   localparam int AW = 5;
   localparam int CW = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          decode_valid;
   logic [AW-1:0] rs1_addr, rs2_addr, rd_addr;
   logic          rs1_used, rs2_used, rd_write, is_load;
   logic          flush, pipe_hold;
   logic [1:0]    rs1_data_bypass, rs2_data_bypass;
   logic          hazard_stall;
   logic [CW-1:0] stall_cycles;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   decode_hazard_forward #(
      .REG_ADDR_WIDTH  (AW),
      .STALL_CNT_WIDTH (CW)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .decode_valid    (decode_valid),
      .rs1_addr        (rs1_addr),
      .rs2_addr        (rs2_addr),
      .rs1_used        (rs1_used),
      .rs2_used        (rs2_used),
      .rd_addr         (rd_addr),
      .rd_write        (rd_write),
      .is_load         (is_load),
      .flush           (flush),
      .pipe_hold       (pipe_hold),
      .rs1_data_bypass (rs1_data_bypass),
      .rs2_data_bypass (rs2_data_bypass),
      .hazard_stall    (hazard_stall),
      .stall_cycles    (stall_cycles)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_stimulus(input logic v, input logic [AW-1:0] r1, input logic u1,
                                 input logic [AW-1:0] r2, input logic u2,
                                 input logic [AW-1:0] rd, input logic wr, input logic ld);
      decode_valid = v;
      rs1_addr     = r1;
      rs1_used     = u1;
      rs2_addr     = r2;
      rs2_used     = u2;
      rd_addr      = rd;
      rd_write     = wr;
      is_load      = ld;
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic check_output(input string tag, input logic [1:0] exp1, input logic [1:0] exp2,
                               input logic exp_stall);
      check({tag, ".rs1"}, {30'd0, rs1_data_bypass}, {30'd0, exp1});
      check({tag, ".rs2"}, {30'd0, rs2_data_bypass}, {30'd0, exp2});
      check({tag, ".stall"}, {31'd0, hazard_stall}, {31'd0, exp_stall});
   endtask

   task automatic check_count(input string tag, input int expected);
      check({tag, ".count"}, {{(32-CW){1'b0}}, stall_cycles}, expected);
   endtask

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      pipe_hold = 1'b0;
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      reset = 1'b0;

      // Empty shadow pipeline: everything from the register file.
      apply_stimulus(1, 1, 1, 2, 1, 8, 1, 0);
      check_output("reset", 2'b00, 2'b00, 1'b0);
      check_count("reset", 0);
      tick();

      // add x5 ; sub x6,x5,x7
      apply_stimulus(1, 0, 0, 0, 0, 5, 1, 0);
      tick();
      apply_stimulus(1, 5, 1, 7, 1, 6, 1, 0);
      check_output("alu_b2b", 2'b01, 2'b00, 1'b0);
      tick();

      // Distance 2: x9 sits in MEM.
      apply_stimulus(1, 0, 0, 0, 0, 9, 1, 0);
      tick();
      apply_stimulus(1, 0, 0, 0, 0, 20, 1, 0);
      tick();
      apply_stimulus(1, 9, 1, 0, 0, 22, 1, 0);
      check_output("dist2", 2'b10, 2'b00, 1'b0);
      tick();

      // Distance 3: x10 sits in WB.
      apply_stimulus(1, 0, 0, 0, 0, 10, 1, 0);
      tick();
      apply_stimulus(1, 0, 0, 0, 0, 20, 1, 0);
      tick();
      apply_stimulus(1, 0, 0, 0, 0, 21, 1, 0);
      tick();
      apply_stimulus(1, 0, 0, 10, 1, 22, 1, 0);
      check_output("dist3", 2'b00, 2'b11, 1'b0);
      tick();

      // Distance 4: x11 has retired.
      apply_stimulus(1, 0, 0, 0, 0, 11, 1, 0);
      tick();
      apply_stimulus(1, 0, 0, 0, 0, 20, 1, 0);
      tick();
      apply_stimulus(1, 0, 0, 0, 0, 21, 1, 0);
      tick();
      apply_stimulus(1, 0, 0, 0, 0, 23, 1, 0);
      tick();
      apply_stimulus(1, 11, 1, 11, 1, 22, 1, 0);
      check_output("dist4", 2'b00, 2'b00, 1'b0);
      tick();

      // lw x3 ; reader of x3 -> two stall cycles, then WB forward.
      apply_stimulus(1, 0, 0, 0, 0, 3, 1, 1);
      tick();
      apply_stimulus(1, 0, 0, 3, 1, 24, 1, 0);
      check_output("lu_c1", 2'b00, 2'b01, 1'b1);
      tick();
      check_output("lu_c2", 2'b00, 2'b10, 1'b1);
      tick();
      check_output("lu_c3", 2'b00, 2'b11, 1'b0);
      check_count("lu", 2);
      tick();

      // x4 written in EX and WB: the younger one wins.
      apply_stimulus(1, 0, 0, 0, 0, 4, 1, 0);
      tick();
      apply_stimulus(1, 0, 0, 0, 0, 21, 1, 0);
      tick();
      apply_stimulus(1, 0, 0, 0, 0, 4, 1, 0);
      tick();
      apply_stimulus(1, 4, 1, 0, 0, 22, 1, 0);
      check_output("youngest", 2'b01, 2'b00, 1'b0);
      tick();

      // lw x0 then a reader of x0: never matches, never stalls.
      apply_stimulus(1, 0, 0, 0, 0, 0, 1, 1);
      tick();
      apply_stimulus(1, 0, 1, 0, 1, 22, 1, 0);
      check_output("x0", 2'b00, 2'b00, 1'b0);
      tick();

      // Load-use stall coinciding with flush: flush wins, bubble enters EX.
      apply_stimulus(1, 0, 0, 0, 0, 3, 1, 1);
      tick();
      flush = 1'b1;
      apply_stimulus(1, 3, 1, 0, 0, 3, 1, 0);
      check_output("flush", 2'b01, 2'b00, 1'b0);
      tick();
      flush = 1'b0;
      check_count("flush", 2);
      apply_stimulus(1, 3, 1, 0, 0, 25, 1, 0);
      check_output("post_flush", 2'b10, 2'b00, 1'b1);
      tick();
      check_output("post_flush_wb", 2'b11, 2'b00, 1'b0);
      check_count("post_flush", 3);
      tick();

      // pipe_hold during a stall freezes entries and the counter.
      apply_stimulus(1, 0, 0, 0, 0, 3, 1, 1);
      tick();
      apply_stimulus(1, 0, 0, 3, 1, 26, 1, 0);
      check_output("hold_pre", 2'b00, 2'b01, 1'b1);
      pipe_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_output($sformatf("hold%0d", i), 2'b00, 2'b01, 1'b1);
         check_count($sformatf("hold%0d", i), 3);
      end
      pipe_hold = 1'b0;
      tick();
      check_output("release1", 2'b00, 2'b10, 1'b1);
      check_count("release1", 4);
      tick();
      check_output("release2", 2'b00, 2'b11, 1'b0);
      check_count("release2", 5);
      tick();

      // Reset in the middle of a stall.
      apply_stimulus(1, 0, 0, 0, 0, 3, 1, 1);
      tick();
      apply_stimulus(1, 3, 1, 0, 0, 27, 1, 0);
      check_output("pre_reset", 2'b01, 2'b00, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_output("mid_reset", 2'b00, 2'b00, 1'b0);
      check_count("mid_reset", 0);

      // Self-dependent load stream: 2 stalls every 3 cycles, counter saturates at 15.
      reset = 1'b1;
      apply_stimulus(1, 3, 1, 0, 0, 3, 1, 1);
      tick();
      reset = 1'b0;
      repeat (9) tick();
      check_count("sat9", 6);
      repeat (12) tick();
      check_count("sat21", 14);
      repeat (9) tick();
      check_count("sat30", 15);
      check_output("sat30", 2'b11, 2'b00, 1'b0);

      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/decode_hazard_forward.md
Name: decode_hazard_forward

Overview:
- Generates per-operand bypass selects and load-use stall for the decode stage.
- Consumes decode register fields and drives `rs1_data_bypass`/`rs2_data_bypass` into the decode bypass mux.
- Keeps a 3-entry shadow pipeline (EX, MEM, WB) of destination-register metadata, advanced in lockstep with the datapath.
- Also counts hazard stall cycles for performance visibility.

Parameters:
- REG_ADDR_WIDTH, 5, register index width (x0 hardwired zero).
- STALL_CNT_WIDTH, 16, width of the saturating stall-cycle counter.

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- decode_valid  input  1  decode holds a real instruction
- rs1_addr  input  REG_ADDR_WIDTH  source register 1 index
- rs2_addr  input  REG_ADDR_WIDTH  source register 2 index
- rs1_used  input  1  instruction reads rs1
- rs2_used  input  1  instruction reads rs2
- rd_addr  input  REG_ADDR_WIDTH  destination index of the decode instruction
- rd_write  input  1  decode instruction writes rd
- is_load  input  1  decode instruction is a load (data valid only at WB)
- flush  input  1  squash the decode instruction (branch redirect)
- pipe_hold  input  1  global freeze (memory wait); shadow pipeline holds
- rs1_data_bypass  output  2  00 regfile, 01 execute, 10 memory, 11 writeback
- rs2_data_bypass  output  2  same encoding for rs2
- hazard_stall  output  1  hold fetch/decode, inject bubble into EX
- stall_cycles  output  STALL_CNT_WIDTH  saturating count of hazard_stall cycles

Behaviour:
- Clocking: one clock `clock`; `reset` is synchronous and active-high.
- Shadow entry fields: valid, rd, wr, load. Stages are EX, MEM, WB.
- Reset: all shadow entries invalid, `stall_cycles`=0. Combinational outputs are therefore 00/00/0 immediately after reset.
- Match rule, per operand s in {rs1, rs2}:
  - A stage matches when used_s && decode_valid && entry.valid && entry.wr && entry.rd==s_addr && s_addr!=0.
- Bypass select, priority youngest first:
  - EX match -> 01; else MEM match -> 10; else WB match -> 11; else 00.
  - Purely combinational, same-cycle.
- Load-use stall:
  - `hazard_stall`=1 if either operand's highest-priority match is a load entry in EX or MEM. Load data exists only at WB.
  - Load in EX matching -> 2 stall cycles; load in MEM matching -> 1 stall cycle.
  - A load in WB forwards normally (11).
  - While `hazard_stall`=1, the bypass select value is don't-care for the consumer, but it is still driven per the priority rule.
- Advance, every cycle with pipe_hold=0:
  - WB<=MEM, MEM<=EX.
  - EX<= {decode_valid && !flush && !hazard_stall, rd_addr, rd_write, is_load}.
- pipe_hold=1: all entries hold. `hazard_stall` is still computed combinationally. `stall_cycles` does not increment.
- flush and hazard_stall in the same cycle:
  - flush wins: `hazard_stall` forced 0 and a bubble enters EX.
  - The counter does not increment.
- rd_addr==0 with rd_write=1 is stored, but never matches because of the s_addr!=0 rule.
- `stall_cycles`: increments when hazard_stall && !pipe_hold && !flush. Saturates at all-ones (no wrap).
- Reset mid-stall: the next cycle has all entries invalid, stall deasserts, counter = 0.
- No X on outputs after the first reset edge. Inputs are required known when decode_valid=1.

Decomposition:
- Shared package `hazard_pkg`:
  - bypass select enum: BYP_REGFILE=2'b00, BYP_EXEC=2'b01, BYP_MEM=2'b10, BYP_WB=2'b11.
  - shadow entry struct {valid, rd, wr, load}.
  - REG_ADDR_WIDTH constant.
- One natural sub-module: `operand_bypass_select`. It takes an operand address/used flag plus the three entries and returns {select, load_hazard}. Instantiate it twice.

Test Plan:
- Back-to-back ALU dependency: "add x5" then "sub x6,x5,x7" in the next cycle -> rs1_data_bypass=01, rs2_data_bypass=00, hazard_stall=0.
- Distance 2 and 3: writer of x9 followed by 1 then 2 independent instructions, then a reader of x9 -> selects 10, then 11 respectively. A distance-4 reader -> 00.
- Load-use: "lw x3" followed immediately by a reader of x3 -> hazard_stall=1 for exactly 2 cycles, then select 11, stall_cycles=2.
- Youngest-wins and x0:
  - x4 written in both EX and WB -> select 01.
  - A reader of x0 while a writer to x0 is in EX -> select 00, no stall.
- Flush and hold:
  - Load-use stall plus flush in the same cycle -> hazard_stall=0, EX bubble, counter unchanged.
  - pipe_hold=1 for 3 cycles during a stall -> entries and counter frozen, stall resumes after release.
- Saturation and reset:
  - Preload the counter near 0xFFFF via a long stall sequence -> it holds at 0xFFFF.
  - reset=1 mid-stall -> next cycle all outputs 0.
